// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU data port and data memory.
// Stores drain in program order; loads that hit a buffered word wait for a full drain.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wmask,
    output logic                  cpu_ready,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  cpu_flush,
    output logic                  flush_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [ADDR_W-1:0]   r_addrMem [DEPTH];
    logic [DATA_W-1:0]   r_dataMem [DEPTH];
    logic [MASK_W-1:0]   r_maskMem [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_flushMode;

    logic                w_empty;
    logic                w_full;
    logic                w_load;
    logic                w_store;
    logic                w_hit;
    logic                w_enq;
    logic                w_deq;
    logic                w_setFlush;

    logic                w_cpuReady;
    logic [DATA_W-1:0]   w_cpuRdata;
    logic                w_flushDone;
    logic                w_memReq;
    logic                w_memWe;
    logic [ADDR_W-1:0]   w_memAddr;
    logic [DATA_W-1:0]   w_memWdata;
    logic [MASK_W-1:0]   w_memWmask;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_load  = cpu_req & ~cpu_we;
    assign w_store = cpu_req & cpu_we;

    // Word-granular match against every occupied slot; byte masks are ignored.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addrMem[i][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_flushMode <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_flushMode <= (r_state == ST_DRAIN) ? (r_flushMode | cpu_flush) : w_setFlush;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_setFlush  = 1'b0;
        w_enq       = 1'b0;
        w_cpuReady  = 1'b0;
        w_cpuRdata  = '0;
        w_flushDone = 1'b0;
        w_memReq    = 1'b0;
        w_memWe     = 1'b0;
        w_memAddr   = '0;
        w_memWdata  = '0;
        w_memWmask  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_store && !w_full) begin
                    w_enq      = 1'b1;
                    w_cpuReady = 1'b1;
                end
                // A missing load owns the memory port; otherwise the head drains.
                if (w_load && !w_hit) begin
                    w_memReq  = 1'b1;
                    w_memAddr = cpu_addr;
                    if (mem_ready) begin
                        w_cpuReady = 1'b1;
                        w_cpuRdata = mem_rdata;
                    end
                end else if (!w_empty) begin
                    w_memReq   = 1'b1;
                    w_memWe    = 1'b1;
                    w_memAddr  = r_addrMem[r_head];
                    w_memWdata = r_dataMem[r_head];
                    w_memWmask = r_maskMem[r_head];
                end
                if (cpu_flush && w_empty) begin
                    w_flushDone = 1'b1;
                end
                if (!w_empty && ((w_load && w_hit) || cpu_flush)) begin
                    w_nextState = ST_DRAIN;
                    w_setFlush  = cpu_flush;
                end
            end
            ST_DRAIN: begin
                if (!w_empty) begin
                    w_memReq   = 1'b1;
                    w_memWe    = 1'b1;
                    w_memAddr  = r_addrMem[r_head];
                    w_memWdata = r_dataMem[r_head];
                    w_memWmask = r_maskMem[r_head];
                end else begin
                    w_nextState = ST_IDLE;
                    w_flushDone = r_flushMode | cpu_flush;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign w_deq = w_memReq & w_memWe & mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addrMem[i] <= '0;
                r_dataMem[i] <= '0;
                r_maskMem[i] <= '0;
            end
        end else begin
            // Enqueue and dequeue never target the same slot: that would need count 0 and DEPTH at once.
            if (w_enq) begin
                r_addrMem[r_tail] <= cpu_addr;
                r_dataMem[r_tail] <= cpu_wdata;
                r_maskMem[r_tail] <= cpu_wmask;
                r_valid[r_tail]   <= 1'b1;
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs are forced low while reset is held so the port goes quiet immediately.
    assign cpu_ready  = reset & w_cpuReady;
    assign cpu_rdata  = {DATA_W{reset}} & w_cpuRdata;
    assign flush_done = reset & w_flushDone;
    assign mem_req    = reset & w_memReq;
    assign mem_we     = reset & w_memWe;
    assign mem_addr   = {ADDR_W{reset}} & w_memAddr;
    assign mem_wdata  = {DATA_W{reset}} & w_memWdata;
    assign mem_wmask  = {MASK_W{reset}} & w_memWmask;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: write-order scoreboard plus per-scenario port checks.
module tb_store_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [MASK_W-1:0] cpu_wmask;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_flush;
    logic              flush_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [103:0]      allOut;

    wr_t expQ[$];
    wr_t obsQ[$];
    int  nCompared   = 0;
    int  nMismatched = 0;

    always #5 clk = ~clk;

    // Memory read data is a fixed function of the address so expected load data is computable.
    function automatic logic [DATA_W-1:0] rdModel(input logic [ADDR_W-1:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    assign mem_rdata = rdModel(mem_addr);
    assign allOut = {cpu_ready, flush_done, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, cpu_rdata};

    store_buffer #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wmask  (cpu_wmask),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_flush  (cpu_flush),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    // Every accepted memory write is captured in order for the scoreboard.
    always @(negedge clk) begin
        if (reset && mem_req && mem_we && mem_ready) begin
            obsQ.push_back(wr_t'({mem_addr, mem_wdata, mem_wmask}));
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wmask = '0;
        cpu_flush = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic applyReset();
        idleInputs();
        reset = 1'b0;
        next();
        next();
        reset = 1'b1;
        expQ.delete();
        obsQ.delete();
        next();
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b0;
        #3;
        nCompared++;
        if (allOut !== 104'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %h want 0", allOut);
        end
        next();
        reset = 1'b1;
        next();
        sample();
        nCompared++;
        if ({mem_req, cpu_ready, flush_done} !== 3'b000) begin
            nMismatched++;
            $display("[TB] FAIL reset_idle: got req/ready/done=%b want 000", {mem_req, cpu_ready, flush_done});
        end
        next();
    endtask

    task automatic test_fill_stall();
        int c;
        applyReset();
        mem_ready = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_wmask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cpu_addr  = 32'h100 + 32'(4 * i);
            cpu_wdata = 32'hA0 + 32'(i);
            sample();
            nCompared++;
            if (cpu_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL fill_accept%0d: got cpu_ready=%b want 1", i, cpu_ready);
            end
            expQ.push_back(wr_t'({cpu_addr, cpu_wdata, cpu_wmask}));
            next();
        end
        cpu_addr  = 32'h110;
        cpu_wdata = 32'hA4;
        sample();
        nCompared++;
        if (cpu_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL full_stall: got cpu_ready=%b want 0", cpu_ready);
        end
        nCompared++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h100}) begin
            nMismatched++;
            $display("[TB] FAIL head_issue: got req=%b we=%b addr=%h want 1 1 00000100", mem_req, mem_we, mem_addr);
        end
        next();
        mem_ready = 1'b1;
        sample();
        nCompared++;
        if (cpu_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL deq_same_cycle: got cpu_ready=%b want 0", cpu_ready);
        end
        next();
        sample();
        nCompared++;
        if (cpu_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fifth_accept: got cpu_ready=%b want 1", cpu_ready);
        end
        expQ.push_back(wr_t'({cpu_addr, cpu_wdata, cpu_wmask}));
        next();
        cpu_req = 1'b0;
        c = 0;
        while (obsQ.size() < 5 && c < 20) begin
            sample();
            next();
            c++;
        end
        for (int k = 0; k < 5; k++) begin
            wr_t o, e;
            nCompared++;
            if (obsQ.size() == 0 || expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL fill_order%0d: got no write want write", k);
            end else begin
                o = obsQ.pop_front();
                e = expQ.pop_front();
                if (o !== e) begin
                    nMismatched++;
                    $display("[TB] FAIL fill_order%0d: got %h want %h", k, o, e);
                end
            end
        end
        sample();
        nCompared++;
        if (obsQ.size() != 0 || mem_req !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fill_quiet: got extra=%0d req=%b want 0 0", obsQ.size(), mem_req);
        end
        next();
    endtask

    task automatic test_load_hit();
        int  stall;
        logic got;
        applyReset();
        mem_ready = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h200;
        cpu_wdata = 32'hDEADBEEF;
        cpu_wmask = 4'h3;
        sample();
        nCompared++;
        if (cpu_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL hit_store: got cpu_ready=%b want 1", cpu_ready);
        end
        expQ.push_back(wr_t'({cpu_addr, cpu_wdata, cpu_wmask}));
        next();
        cpu_we   = 1'b0;
        cpu_addr = 32'h202;
        stall = 0;
        got   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (cpu_ready) begin
                got = 1'b1;
                break;
            end
            stall++;
            next();
        end
        nCompared++;
        if (!got || stall == 0) begin
            nMismatched++;
            $display("[TB] FAIL hit_stall: got done=%b stall=%0d want 1 and stall>0", got, stall);
        end
        nCompared++;
        if (obsQ.size() != 1) begin
            nMismatched++;
            $display("[TB] FAIL hit_drain_first: got %0d writes want 1", obsQ.size());
        end else begin
            wr_t o, e;
            o = obsQ.pop_front();
            e = expQ.pop_front();
            if (o !== e) begin
                nMismatched++;
                $display("[TB] FAIL hit_drain_first: got %h want %h", o, e);
            end
        end
        nCompared++;
        if ({mem_we, mem_addr, cpu_rdata} !== {1'b0, 32'h202, rdModel(32'h202)}) begin
            nMismatched++;
            $display("[TB] FAIL hit_read: got we=%b addr=%h rdata=%h want 0 00000202 %h", mem_we, mem_addr, cpu_rdata, rdModel(32'h202));
        end
        next();
        cpu_req = 1'b0;
        expQ.delete();
    endtask

    task automatic test_load_bypass();
        applyReset();
        mem_ready = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h100;
        cpu_wdata = 32'h11;
        cpu_wmask = 4'hF;
        expQ.push_back(wr_t'({cpu_addr, cpu_wdata, cpu_wmask}));
        next();
        mem_ready = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h300;
        sample();
        nCompared++;
        if ({cpu_ready, mem_we, mem_addr, cpu_rdata} !== {1'b1, 1'b0, 32'h300, rdModel(32'h300)} || obsQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL bypass_read: got ready=%b we=%b addr=%h rdata=%h writes=%0d want 1 0 00000300 %h 0",
                     cpu_ready, mem_we, mem_addr, cpu_rdata, obsQ.size(), rdModel(32'h300));
        end
        next();
        cpu_req = 1'b0;
        sample();
        nCompared++;
        if (obsQ.size() != 1) begin
            nMismatched++;
            $display("[TB] FAIL bypass_drain_next: got %0d writes want 1", obsQ.size());
        end else begin
            wr_t o, e;
            o = obsQ.pop_front();
            e = expQ.pop_front();
            if (o !== e) begin
                nMismatched++;
                $display("[TB] FAIL bypass_drain_next: got %h want %h", o, e);
            end
        end
        next();
        expQ.delete();
    endtask

    task automatic test_flush();
        logic [3:0] pat;
        int pulses;
        int writesAtDone;
        applyReset();
        mem_ready = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_wmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cpu_addr  = 32'h400 + 32'(4 * i);
            cpu_wdata = 32'hC0 + 32'(i);
            expQ.push_back(wr_t'({cpu_addr, cpu_wdata, cpu_wmask}));
            next();
        end
        cpu_req      = 1'b0;
        cpu_flush    = 1'b1;
        pat          = 4'b1101;
        pulses       = 0;
        writesAtDone = -1;
        for (int c = 0; c < 14; c++) begin
            mem_ready = (c < 4) ? pat[c] : 1'b1;
            sample();
            if (flush_done) begin
                pulses++;
                writesAtDone = obsQ.size();
                cpu_flush = 1'b0;
            end
            next();
        end
        cpu_flush = 1'b0;
        nCompared++;
        if (pulses != 1 || writesAtDone != 3) begin
            nMismatched++;
            $display("[TB] FAIL flush_done_pulse: got pulses=%0d writes_at_done=%0d want 1 3", pulses, writesAtDone);
        end
        nCompared++;
        if (obsQ.size() != 3) begin
            nMismatched++;
            $display("[TB] FAIL flush_write_count: got %0d want 3", obsQ.size());
        end
        for (int k = 0; k < 3; k++) begin
            wr_t o, e;
            nCompared++;
            if (obsQ.size() == 0 || expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL flush_order%0d: got no write want write", k);
            end else begin
                o = obsQ.pop_front();
                e = expQ.pop_front();
                if (o !== e) begin
                    nMismatched++;
                    $display("[TB] FAIL flush_order%0d: got %h want %h", k, o, e);
                end
            end
        end
        cpu_flush = 1'b1;
        sample();
        nCompared++;
        if ({flush_done, mem_req} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL flush_empty: got done=%b req=%b want 1 0", flush_done, mem_req);
        end
        next();
        cpu_flush = 1'b0;
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        int idx;
        int c;
        applyReset();
        idx = 0;
        c   = 0;
        while (idx < 10 && c < 80) begin
            mem_ready = (c % 2 == 1);
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 32'h500 + 32'(4 * idx);
            cpu_wdata = 32'hB00 + 32'(idx);
            cpu_wmask = 4'(idx) | 4'h1;
            sample();
            if (cpu_ready) begin
                expQ.push_back(wr_t'({cpu_addr, cpu_wdata, cpu_wmask}));
                idx++;
            end
            next();
            c++;
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b1;
        nCompared++;
        if (idx != 10) begin
            nMismatched++;
            $display("[TB] FAIL wrap_accepts: got %0d want 10", idx);
        end
        c = 0;
        while (obsQ.size() < 10 && c < 30) begin
            sample();
            next();
            c++;
        end
        for (int k = 0; k < 10; k++) begin
            wr_t o, e;
            nCompared++;
            if (obsQ.size() == 0 || expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL wrap_order%0d: got no write want write", k);
            end else begin
                o = obsQ.pop_front();
                e = expQ.pop_front();
                if (o !== e) begin
                    nMismatched++;
                    $display("[TB] FAIL wrap_order%0d: got %h want %h", k, o, e);
                end
            end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_reset_mid();
        logic sawReq;
        applyReset();
        mem_ready = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_wmask = 4'hF;
        cpu_addr  = 32'h600;
        cpu_wdata = 32'h66;
        next();
        cpu_addr  = 32'h604;
        cpu_wdata = 32'h67;
        next();
        cpu_req = 1'b0;
        sample();
        nCompared++;
        if (mem_req !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL pending_req: got mem_req=%b want 1", mem_req);
        end
        #1;
        reset = 1'b0;
        #1;
        nCompared++;
        if (allOut !== 104'd0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset_outputs: got %h want 0", allOut);
        end
        @(posedge clk);
        #3;
        reset     = 1'b1;
        mem_ready = 1'b1;
        sawReq    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            if (mem_req) sawReq = 1'b1;
            next();
        end
        nCompared++;
        if (sawReq || obsQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL stale_write: got req_seen=%b writes=%0d want 0 0", sawReq, obsQ.size());
        end
        cpu_flush = 1'b1;
        sample();
        nCompared++;
        if ({flush_done, mem_req} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL count_zero_after_reset: got done=%b req=%b want 1 0", flush_done, mem_req);
        end
        next();
        cpu_flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_stall();
        test_load_hit();
        test_load_bypass();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
